// File: rtl/psg_i2s_out_pkg.sv
// Shared PSG audio constants and types for psg_i2s_out and its I2S transmitter.
// Later PSG audio consumers are expected to import this package as well.
package psg_i2s_out_pkg;

  localparam int FRAME_SLOTS = 64;   // bclk periods per I2S frame
  localparam int WORD_BITS   = 16;   // PCM word width
  localparam int ACC_W       = 10;   // density counter width, holds 0..512
  localparam int MIX_W       = 11;   // mixer sum width, holds 0..1536
  localparam int PCM_SHIFT   = 5;    // scale from mix units to PCM units

  localparam logic [ACC_W-1:0]            ACC_MAX = 10'd512;
  localparam logic signed [WORD_BITS-1:0] MIX_MID = 16'sd768;

  typedef logic signed [WORD_BITS-1:0] pcm_t;

endpackage

// File: rtl/psg_i2s_out_i2s_tx.sv
// Free-running I2S master transmitter (Philips format). Owns the frame counter,
// bclk/lrclk generation and the 64-bit frame shifter. A new frame word
// {L, 0, R, 0} is loaded at the frame boundary when load_i is high; the
// trailing zero of the previous frame goes out in slot 0 of the next one.
module i2s_tx
  import psg_i2s_out_pkg::*;
#(
  parameter int BCLK_HALF = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic [WORD_BITS-1:0] left_i,
  input  logic [WORD_BITS-1:0] right_i,
  output logic                 frame_start_o,
  output logic                 bclk_o,
  output logic                 lrclk_o,
  output logic                 sdata_o
);

  localparam int FCNT_W = $clog2(2 * BCLK_HALF * FRAME_SLOTS);
  localparam int PH_W   = $clog2(2 * BCLK_HALF);

  logic [FCNT_W-1:0]      fcnt_q, fcnt_d;
  logic [FRAME_SLOTS-1:0] sh_q, sh_d;
  logic                   bclk_q, bclk_d;
  logic                   lrclk_q, lrclk_d;
  logic                   sdata_q, sdata_d;
  logic                   slot_start;

  assign frame_start_o = (fcnt_q == '0);
  assign slot_start    = (fcnt_q[PH_W-1:0] == '0);

  // Next-state: counter wraps at the power-of-two frame length; the shifter
  // presents one bit per slot start and reloads at the boundary.
  always_comb begin
    fcnt_d  = fcnt_q + 1'b1;
    bclk_d  = fcnt_q[PH_W-1];
    lrclk_d = fcnt_q[FCNT_W-1];
    sdata_d = sdata_q;
    sh_d    = sh_q;
    if (slot_start) begin
      sdata_d = sh_q[FRAME_SLOTS-1];
      sh_d    = {sh_q[FRAME_SLOTS-2:0], 1'b0};
    end
    if (frame_start_o && load_i) begin
      sh_d = {left_i, {WORD_BITS{1'b0}}, right_i, {WORD_BITS{1'b0}}};
    end
  end

  // State and registered outputs; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      fcnt_q  <= '0;
      sh_q    <= '0;
      bclk_q  <= 1'b0;
      lrclk_q <= 1'b0;
      sdata_q <= 1'b0;
    end else begin
      fcnt_q  <= fcnt_d;
      sh_q    <= sh_d;
      bclk_q  <= bclk_d;
      lrclk_q <= lrclk_d;
      sdata_q <= sdata_d;
    end
  end

  assign bclk_o  = bclk_q;
  assign lrclk_o = lrclk_q;
  assign sdata_o = sdata_q;

endmodule

// File: rtl/psg_i2s_out.sv
// PSG audio output stage: density-counts the three PSG channel bits over one
// I2S frame, mixes them into signed 16-bit PCM and streams it as I2S master.
// Optional build macro STEREO_EN selects ABC stereo (L=2A+B, R=2C+B);
// without it the mix is mono (L=R=A+B+C).
module psg_i2s_out
  import psg_i2s_out_pkg::*;
#(
  parameter int BCLK_HALF = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] ain,
  input  logic       mute,
  output logic       sample_tick,
  output logic       i2s_bclk,
  output logic       i2s_lrclk,
  output logic       i2s_sdata
);

  // Saturating density count; restarts from the current bit at the boundary.
  function automatic logic [ACC_W-1:0] acc_next(input logic [ACC_W-1:0] acc,
                                                input logic bit_i,
                                                input logic start);
    if (start) return {{(ACC_W-1){1'b0}}, bit_i};
    if (bit_i && (acc != ACC_MAX)) return acc + 1'b1;
    return acc;
  endfunction

  // Centre the mix around zero and scale to PCM; the range never clips.
  function automatic pcm_t pcm_of(input logic [MIX_W-1:0] mix);
    pcm_t diff;
    diff = $signed({{(WORD_BITS-MIX_W){1'b0}}, mix}) - MIX_MID;
    return diff <<< PCM_SHIFT;
  endfunction

  logic [ACC_W-1:0]     acc_a_q, acc_a_d;
  logic [ACC_W-1:0]     acc_b_q, acc_b_d;
  logic [ACC_W-1:0]     acc_c_q, acc_c_d;
  logic                 armed_q, armed_d;
  logic                 tick_q, tick_d;
  logic                 frame_start;
  logic [MIX_W-1:0]     mix_l, mix_r;
  pcm_t                 pcm_l, pcm_r;
  logic [WORD_BITS-1:0] word_l, word_r;

  // Mixer over the completed window (accumulators hold it during fcnt==0).
  always_comb begin
`ifdef STEREO_EN
    mix_l = {acc_a_q, 1'b0} + MIX_W'(acc_b_q);
    mix_r = {acc_c_q, 1'b0} + MIX_W'(acc_b_q);
`else
    mix_l = MIX_W'(acc_a_q) + MIX_W'(acc_b_q) + MIX_W'(acc_c_q);
    mix_r = mix_l;
`endif
    pcm_l = pcm_of(mix_l);
    pcm_r = pcm_of(mix_r);
    // The first boundary after reset only closes an empty window, and mute
    // forces silence; either way the latched words are zero.
    if (mute || !armed_q) begin
      word_l = '0;
      word_r = '0;
    end else begin
      word_l = pcm_l;
      word_r = pcm_r;
    end
  end

  // Next-state for accumulators, first-frame flag and sample tick.
  always_comb begin
    acc_a_d = acc_next(acc_a_q, ain[0], frame_start);
    acc_b_d = acc_next(acc_b_q, ain[1], frame_start);
    acc_c_d = acc_next(acc_c_q, ain[2], frame_start);
    armed_d = armed_q | frame_start;
    tick_d  = frame_start;
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_a_q <= '0;
      acc_b_q <= '0;
      acc_c_q <= '0;
      armed_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      acc_a_q <= acc_a_d;
      acc_b_q <= acc_b_d;
      acc_c_q <= acc_c_d;
      armed_q <= armed_d;
      tick_q  <= tick_d;
    end
  end

  assign sample_tick = tick_q;

  i2s_tx #(
    .BCLK_HALF(BCLK_HALF)
  ) u_tx (
    .clk          (clk),
    .reset        (reset),
    .load_i       (frame_start),
    .left_i       (word_l),
    .right_i      (word_r),
    .frame_start_o(frame_start),
    .bclk_o       (i2s_bclk),
    .lrclk_o      (i2s_lrclk),
    .sdata_o      (i2s_sdata)
  );

endmodule
